// File: rtl/id_ex_stage_pkg.sv
// Shared opcode, ALU-op and control-bundle definitions for the ID/EX boundary.
package id_ex_stage_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_BR   = 2'b01;
   localparam logic [1:0] ALU_FUNC = 2'b10;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic       branch;
      logic [1:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_control_decode.sv
// Main control decode: opcode to control bundle plus source-register usage flags.
module id_ex_stage_control_decode
   import id_ex_stage_pkg::*;
(
   input  logic [6:0] opcode,
   output ctrl_t      ctrl,
   output logic       rs1_used,
   output logic       rs2_used
);

   always_comb begin
      ctrl     = CTRL_NOP;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      case (opcode)
         OP_R: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_FUNC;
            rs1_used       = 1'b1;
            rs2_used       = 1'b1;
         end
         OP_IMM: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_FUNC;
            rs1_used       = 1'b1;
         end
         OP_LOAD: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.alu_op     = ALU_ADD;
            rs1_used        = 1'b1;
         end
         OP_STORE: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_ADD;
            rs1_used       = 1'b1;
            rs2_used       = 1'b1;
         end
         OP_BRANCH: begin
            ctrl.branch = 1'b1;
            ctrl.alu_op = ALU_BR;
            rs1_used    = 1'b1;
            rs2_used    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold handling
// and a saturating count of inserted bubbles.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int BUB_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [XLEN-1:0]      PC_ID,
   input  logic [XLEN-1:0]      IMM_ID,
   input  logic [XLEN-1:0]      REG_DATA1_ID,
   input  logic [XLEN-1:0]      REG_DATA2_ID,
   input  logic [2:0]           FUNCT3_ID,
   input  logic [6:0]           FUNCT7_ID,
   input  logic [6:0]           OPCODE_ID,
   input  logic [4:0]           RD_ID,
   input  logic [4:0]           RS1_ID,
   input  logic [4:0]           RS2_ID,
   input  logic                 PCSrc_EX,
   input  logic                 hold_EX,
   output logic [XLEN-1:0]      PC_EX,
   output logic [XLEN-1:0]      IMM_EX,
   output logic [XLEN-1:0]      REG_DATA1_EX,
   output logic [XLEN-1:0]      REG_DATA2_EX,
   output logic [2:0]           FUNCT3_EX,
   output logic [6:0]           FUNCT7_EX,
   output logic [4:0]           RD_EX,
   output logic [4:0]           RS1_EX,
   output logic [4:0]           RS2_EX,
   output logic                 RegWrite_EX,
   output logic                 MemRead_EX,
   output logic                 MemWrite_EX,
   output logic                 MemtoReg_EX,
   output logic                 ALUSrc_EX,
   output logic                 Branch_EX,
   output logic [1:0]           ALUOp_EX,
   output logic                 PC_write,
   output logic                 IF_ID_write,
   output logic                 IF_ID_flush,
   output logic [BUB_CNT_W-1:0] bubble_count
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [2:0]      f3;
      logic [6:0]      f7;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      ctrl_t           ctrl;
   } ex_t;

   ex_t                  ex_q, ex_d;
   logic [BUB_CNT_W-1:0] bub_cnt_q, bub_cnt_d;
   ctrl_t                ctrl_id;
   logic                 rs1_used, rs2_used;
   logic                 load_use;

   id_ex_stage_control_decode u_decode (
      .opcode   (OPCODE_ID),
      .ctrl     (ctrl_id),
      .rs1_used (rs1_used),
      .rs2_used (rs2_used)
   );

   // x0 is hardwired zero, so a load targeting it can never create a hazard.
   assign load_use = ex_q.ctrl.mem_read && (ex_q.rd != 5'd0) &&
                     ((rs1_used && (RS1_ID == ex_q.rd)) ||
                      (rs2_used && (RS2_ID == ex_q.rd)));

   assign PC_write    = !hold_EX && (PCSrc_EX || !load_use);
   assign IF_ID_write = !hold_EX && (PCSrc_EX || !load_use);
   assign IF_ID_flush = !hold_EX && PCSrc_EX;

   always_comb begin
      ex_d      = ex_q;
      bub_cnt_d = bub_cnt_q;
      if (!hold_EX) begin
         if (PCSrc_EX || load_use) begin
            ex_d = '0;
            if (bub_cnt_q != '1) bub_cnt_d = bub_cnt_q + BUB_CNT_W'(1);
         end else begin
            ex_d.pc   = PC_ID;
            ex_d.imm  = IMM_ID;
            ex_d.rd1  = REG_DATA1_ID;
            ex_d.rd2  = REG_DATA2_ID;
            ex_d.f3   = FUNCT3_ID;
            ex_d.f7   = FUNCT7_ID;
            ex_d.rd   = RD_ID;
            ex_d.rs1  = RS1_ID;
            ex_d.rs2  = RS2_ID;
            ex_d.ctrl = ctrl_id;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q      <= '0;
         bub_cnt_q <= '0;
      end else begin
         ex_q      <= ex_d;
         bub_cnt_q <= bub_cnt_d;
      end
   end

   assign PC_EX        = ex_q.pc;
   assign IMM_EX       = ex_q.imm;
   assign REG_DATA1_EX = ex_q.rd1;
   assign REG_DATA2_EX = ex_q.rd2;
   assign FUNCT3_EX    = ex_q.f3;
   assign FUNCT7_EX    = ex_q.f7;
   assign RD_EX        = ex_q.rd;
   assign RS1_EX       = ex_q.rs1;
   assign RS2_EX       = ex_q.rs2;
   assign RegWrite_EX  = ex_q.ctrl.reg_write;
   assign MemRead_EX   = ex_q.ctrl.mem_read;
   assign MemWrite_EX  = ex_q.ctrl.mem_write;
   assign MemtoReg_EX  = ex_q.ctrl.mem_to_reg;
   assign ALUSrc_EX    = ex_q.ctrl.alu_src;
   assign Branch_EX    = ex_q.ctrl.branch;
   assign ALUOp_EX     = ex_q.ctrl.alu_op;
   assign bubble_count = bub_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes predicted responses, a
// monitor pops and compares them each cycle. Second instance uses a 2-bit counter.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] PC_ID = '0, IMM_ID = '0, REG_DATA1_ID = '0, REG_DATA2_ID = '0;
   logic [2:0]  FUNCT3_ID = '0;
   logic [6:0]  FUNCT7_ID = '0, OPCODE_ID = '0;
   logic [4:0]  RD_ID = '0, RS1_ID = '0, RS2_ID = '0;
   logic        PCSrc_EX = 1'b0, hold_EX = 1'b0;

   logic [31:0] PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX;
   logic [2:0]  FUNCT3_EX;
   logic [6:0]  FUNCT7_EX;
   logic [4:0]  RD_EX, RS1_EX, RS2_EX;
   logic        RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, ALUSrc_EX, Branch_EX;
   logic [1:0]  ALUOp_EX;
   logic        PC_write, IF_ID_write, IF_ID_flush;
   logic [15:0] bubble_count;

   logic [31:0] b_pc, b_imm, b_d1, b_d2;
   logic [2:0]  b_f3;
   logic [6:0]  b_f7;
   logic [4:0]  b_rd, b_rs1, b_rs2;
   logic        b_rw, b_mr, b_mw, b_m2r, b_as, b_br;
   logic [1:0]  b_aluop;
   logic        b_pcw, b_ifw, b_flush;
   logic [1:0]  b_cnt;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(32), .BUB_CNT_W(16)) dut (
      .clk(clk), .reset(reset), .PC_ID(PC_ID), .IMM_ID(IMM_ID),
      .REG_DATA1_ID(REG_DATA1_ID), .REG_DATA2_ID(REG_DATA2_ID),
      .FUNCT3_ID(FUNCT3_ID), .FUNCT7_ID(FUNCT7_ID), .OPCODE_ID(OPCODE_ID),
      .RD_ID(RD_ID), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
      .PCSrc_EX(PCSrc_EX), .hold_EX(hold_EX),
      .PC_EX(PC_EX), .IMM_EX(IMM_EX), .REG_DATA1_EX(REG_DATA1_EX), .REG_DATA2_EX(REG_DATA2_EX),
      .FUNCT3_EX(FUNCT3_EX), .FUNCT7_EX(FUNCT7_EX), .RD_EX(RD_EX), .RS1_EX(RS1_EX), .RS2_EX(RS2_EX),
      .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
      .MemtoReg_EX(MemtoReg_EX), .ALUSrc_EX(ALUSrc_EX), .Branch_EX(Branch_EX), .ALUOp_EX(ALUOp_EX),
      .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
      .bubble_count(bubble_count)
   );

   id_ex_stage #(.XLEN(32), .BUB_CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .PC_ID(PC_ID), .IMM_ID(IMM_ID),
      .REG_DATA1_ID(REG_DATA1_ID), .REG_DATA2_ID(REG_DATA2_ID),
      .FUNCT3_ID(FUNCT3_ID), .FUNCT7_ID(FUNCT7_ID), .OPCODE_ID(OPCODE_ID),
      .RD_ID(RD_ID), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
      .PCSrc_EX(PCSrc_EX), .hold_EX(hold_EX),
      .PC_EX(b_pc), .IMM_EX(b_imm), .REG_DATA1_EX(b_d1), .REG_DATA2_EX(b_d2),
      .FUNCT3_EX(b_f3), .FUNCT7_EX(b_f7), .RD_EX(b_rd), .RS1_EX(b_rs1), .RS2_EX(b_rs2),
      .RegWrite_EX(b_rw), .MemRead_EX(b_mr), .MemWrite_EX(b_mw),
      .MemtoReg_EX(b_m2r), .ALUSrc_EX(b_as), .Branch_EX(b_br), .ALUOp_EX(b_aluop),
      .PC_write(b_pcw), .IF_ID_write(b_ifw), .IF_ID_flush(b_flush),
      .bubble_count(b_cnt)
   );

   typedef struct {
      bit [31:0] pc, imm, d1, d2;
      bit [2:0]  f3;
      bit [6:0]  f7;
      bit [4:0]  rd, rs1, rs2;
      bit [7:0]  ctrl;   // {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,Branch,ALUOp}
   } st_t;

   typedef struct {
      bit  comb_ok;
      bit  pcw, ifw, flush;
      st_t nxt;
      int  cnt;
   } exp_t;

   exp_t sb[$];
   st_t  m;
   int   mcnt = 0;
   bit   m_known = 0;
   int   checks = 0;
   int   errors = 0;

   localparam bit [6:0] OPR = 7'b0110011, OPI = 7'b0010011, OPL = 7'b0000011,
                        OPS = 7'b0100011, OPB = 7'b1100011, OPJ = 7'b1101111;

   function automatic bit [7:0] dec(bit [6:0] op);
      case (op)
         OPR:     return 8'b1000_0010;
         OPI:     return 8'b1000_1010;
         OPL:     return 8'b1101_1000;
         OPS:     return 8'b0010_1000;
         OPB:     return 8'b0000_0101;
         default: return 8'b0000_0000;
      endcase
   endfunction

   function automatic bit uses_rs1(bit [6:0] op);
      return op inside {OPR, OPI, OPL, OPS, OPB};
   endfunction

   function automatic bit uses_rs2(bit [6:0] op);
      return op inside {OPR, OPS, OPB};
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(bit r, bit [6:0] op, bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2,
                      bit [31:0] d1, bit flush, bit hd);
      exp_t e;
      st_t  zero;
      bit   lu;
      @(negedge clk);
      reset = r; OPCODE_ID = op; RD_ID = rd; RS1_ID = rs1; RS2_ID = rs2;
      REG_DATA1_ID = d1; PCSrc_EX = flush; hold_EX = hd;
      PC_ID = $urandom; IMM_ID = $urandom; REG_DATA2_ID = $urandom;
      FUNCT3_ID = 3'($urandom); FUNCT7_ID = 7'($urandom);
      zero = '{default: 0};
      lu = m.ctrl[6] && (m.rd != 0) &&
           ((uses_rs1(op) && rs1 == m.rd) || (uses_rs2(op) && rs2 == m.rd));
      e.comb_ok = m_known;
      e.pcw     = !hd && (flush || !lu);
      e.ifw     = e.pcw;
      e.flush   = !hd && flush;
      if (r) begin
         m = zero; mcnt = 0; m_known = 1;
      end else if (hd) begin
      end else if (flush || lu) begin
         m = zero; mcnt++;
      end else begin
         m = '{pc: PC_ID, imm: IMM_ID, d1: d1, d2: REG_DATA2_ID, f3: FUNCT3_ID,
               f7: FUNCT7_ID, rd: rd, rs1: rs1, rs2: rs2, ctrl: dec(op)};
      end
      e.nxt = m;
      e.cnt = mcnt;
      sb.push_back(e);
   endtask

   // Monitor: combinational outputs sampled mid-low-phase, registers after the edge.
   initial begin
      logic s_pcw, s_ifw, s_flush;
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         s_pcw = PC_write; s_ifw = IF_ID_write; s_flush = IF_ID_flush;
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.comb_ok) begin
               chk("PC_write", s_pcw, e.pcw);
               chk("IF_ID_write", s_ifw, e.ifw);
               chk("IF_ID_flush", s_flush, e.flush);
            end
            chk("PC_EX", PC_EX, e.nxt.pc);
            chk("IMM_EX", IMM_EX, e.nxt.imm);
            chk("REG_DATA1_EX", REG_DATA1_EX, e.nxt.d1);
            chk("REG_DATA2_EX", REG_DATA2_EX, e.nxt.d2);
            chk("FUNCT3_EX", FUNCT3_EX, e.nxt.f3);
            chk("FUNCT7_EX", FUNCT7_EX, e.nxt.f7);
            chk("RD_EX", RD_EX, e.nxt.rd);
            chk("RS1_EX", RS1_EX, e.nxt.rs1);
            chk("RS2_EX", RS2_EX, e.nxt.rs2);
            chk("ctrl_EX", {RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX,
                            ALUSrc_EX, Branch_EX, ALUOp_EX}, e.nxt.ctrl);
            chk("bubble_count", bubble_count, e.cnt);
            chk("bubble_count_sat", b_cnt, (e.cnt > 3) ? 3 : e.cnt);
         end
      end
   end

   initial begin
      int sel;
      bit [6:0] ops [6];
      ops = '{OPR, OPI, OPL, OPS, OPB, OPJ};
      // reset with random ID inputs
      repeat (2) cyc(1, ops[$urandom_range(0, 5)], 5'($urandom), 5'($urandom),
                     5'($urandom), $urandom, 1'($urandom), 1'($urandom));
      cyc(0, OPR, 5, 1, 2, 7, 0, 0);          // normal add
      cyc(0, OPL, 3, 1, 0, 0, 0, 0);          // lw x3
      cyc(0, OPR, 6, 4, 3, 11, 0, 0);         // add uses x3 -> stall
      cyc(0, OPR, 6, 4, 3, 11, 0, 0);         // add enters EX
      cyc(0, OPL, 0, 1, 0, 0, 0, 0);          // load to x0
      cyc(0, OPR, 8, 0, 0, 1, 0, 0);          // no stall on x0
      cyc(0, OPL, 7, 1, 0, 0, 0, 0);
      cyc(0, OPI, 9, 1, 7, 2, 0, 0);          // rs2 unused by I-ALU
      cyc(0, OPL, 3, 1, 0, 0, 0, 0);
      cyc(0, OPR, 6, 3, 2, 5, 1, 0);          // flush beats stall
      cyc(0, OPL, 3, 1, 0, 0, 0, 0);
      repeat (3) cyc(0, OPR, 6, 4, 3, 5, 0, 1);  // hold during load-use
      cyc(0, OPR, 6, 4, 3, 5, 0, 0);
      cyc(0, OPR, 6, 4, 3, 5, 0, 0);
      repeat (5) cyc(0, OPB, 0, 1, 2, 3, 1, 0);  // saturation on 2-bit counter
      cyc(0, OPL, 3, 1, 0, 0, 0, 0);
      cyc(1, OPR, 6, 3, 2, 5, 0, 0);          // reset mid-stall
      cyc(0, OPS, 0, 3, 3, 5, 0, 0);
      for (int i = 0; i < 400; i++) begin
         sel = $urandom_range(0, 5);
         cyc(($urandom_range(0, 99) < 3), ops[sel], 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom,
             ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 15));
      end
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute boundary of the 5-stage RISC-V pipeline; sits directly downstream of the IF/ID block.
- Decodes main control from OPCODE_ID and registers all ID outputs plus control into the ID/EX pipeline register.
- Detects load-use hazards and drives PC_write / IF_ID_write back to fetch/decode.
- Inserts bubbles on stall or taken-branch flush; freezes on downstream hold; counts bubbles inserted.

Parameters:
XLEN, 32, datapath width (PC, immediate, register data)
BUB_CNT_W, 16, width of saturating bubble counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
PC_ID  input  XLEN  PC of instruction in ID
IMM_ID  input  XLEN  sign-extended immediate
REG_DATA1_ID  input  XLEN  rs1 read data
REG_DATA2_ID  input  XLEN  rs2 read data
FUNCT3_ID  input  3  funct3
FUNCT7_ID  input  7  funct7
OPCODE_ID  input  7  opcode
RD_ID  input  5  destination register
RS1_ID  input  5  source register 1
RS2_ID  input  5  source register 2
PCSrc_EX  input  1  branch taken in EX; flush request
hold_EX  input  1  downstream freeze request
PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX  output  XLEN each  registered copies
FUNCT3_EX  output  3  registered
FUNCT7_EX  output  7  registered
RD_EX, RS1_EX, RS2_EX  output  5 each  registered
RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, ALUSrc_EX, Branch_EX  output  1 each  registered control
ALUOp_EX  output  2  registered ALU op class
PC_write  output  1  0 = hold PC (combinational)
IF_ID_write  output  1  0 = hold IF/ID register (combinational)
IF_ID_flush  output  1  1 = IF/ID must load NOP (combinational)
bubble_count  output  BUB_CNT_W  saturating count of bubbles inserted

Behaviour:
- Reset: all registered outputs 0 (bubble), bubble_count 0. Combinational outputs then follow their equations from the cleared state. Reset takes priority over all other inputs at the same edge.
- Control decode:
  - 0110011 R: RegWrite=1, ALUOp=10.
  - 0010011 I-ALU: RegWrite=1, ALUSrc=1, ALUOp=10.
  - 0000011 load: RegWrite, MemRead, MemtoReg, ALUSrc =1, ALUOp=00.
  - 0100011 store: MemWrite=1, ALUSrc=1, ALUOp=00.
  - 1100011 branch: Branch=1, ALUOp=01.
  - Any other opcode: all control 0.
- Source use: rs1 used by R, I-ALU, load, store, branch. rs2 used by R, store, branch only.
- load_use = MemRead_EX && RD_EX!=0 && ((rs1 used && RS1_ID==RD_EX) || (rs2 used && RS2_ID==RD_EX)).
- Edge update priority: reset > hold_EX > PCSrc_EX > load_use > normal.
  - hold_EX=1: ID/EX register and bubble_count unchanged; PC_write=0, IF_ID_write=0, IF_ID_flush=0.
  - PCSrc_EX=1 (no hold): bubble loaded (all control 0, data fields 0); PC_write=1, IF_ID_write=1, IF_ID_flush=1; bubble_count+1. Flush overrides load_use.
  - load_use (no hold, no flush): bubble loaded; PC_write=0, IF_ID_write=0, IF_ID_flush=0; bubble_count+1.
  - Normal: all ID fields and decoded control registered; PC_write=1, IF_ID_write=1, IF_ID_flush=0.
- Latency: 1 cycle ID to EX. Load-use costs exactly one bubble, because the bubble clears MemRead_EX at the next edge.
- bubble_count saturates at all-ones; it does not wrap.
- Reset asserted mid-stall: next edge yields a cleared register, and PC_write returns to 1.
- RD_EX=0 never triggers a stall.

Decomposition:
- Shared package: opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH), ALUOp encodings (ALU_ADD=00, ALU_BR=01, ALU_FUNC=10), XLEN default.
- One sub-module: control_decode, purely combinational (opcode -> control bits, rs1/rs2-used flags).
- Hazard logic, register and counter stay in id_ex_stage.

Test Plan:
- Reset: reset=1 for 2 cycles with random ID inputs -> all *_EX outputs 0, bubble_count=0, PC_write=1, IF_ID_write=1.
- Normal add: OPCODE_ID=0110011, RD_ID=5, REG_DATA1_ID=7 -> next cycle RegWrite_EX=1, ALUOp_EX=10, RD_EX=5, REG_DATA1_EX=7, PC_write=1.
- Load-use: lw x3 in EX (MemRead_EX=1, RD_EX=3), add with RS2_ID=3 in ID -> PC_write=0, IF_ID_write=0. Next edge: bubble (RegWrite_EX=0), bubble_count=1. Following edge: add enters EX.
- No false stall: load RD_EX=0 with RS1_ID=0, or I-ALU in ID with RS2_ID==RD_EX -> PC_write=1, no bubble.
- Flush beats stall: load_use and PCSrc_EX=1 in the same cycle -> IF_ID_flush=1, PC_write=1, bubble loaded, bubble_count increments by 1.
- Hold: hold_EX=1 for 3 cycles during a load_use condition -> *_EX and bubble_count frozen, PC_write=0. After release: normal stall resolution.
- Saturation: BUB_CNT_W=2, 5 consecutive flushes -> bubble_count=3.
